// File: rtl/noc_msg_port.sv
// ============================================================================
// Module      : noc_msg_port
// Description : Node-side message adapter for a 2-VC, 16-bit-payload NoC.
//               Splits 32-bit outbound messages into a head/tail flit pair
//               injected on VC0 (gated by the network's VC0 non-full status),
//               buffers inbound flits in a small FIFO with credit feedback,
//               and reassembles inbound flit pairs into 32-bit messages.
//
// Ports       : clk, res_n            clock / async active-low reset
//               tx_valid/ready/dest/data   outbound message handshake
//               rx_valid/ready/data        inbound reassembled message
//               err[2:0]                   sticky {misroute, protocol, overflow}
//               put_flit, en_put           flit toward network
//               en_get_non_full_VCs, get_non_full_VCs   network VC status
//               en_get, get_flit           flit from network
//               put_non_full_VCs, en_put_non_full_VCs   local credit status
//               this_id                    node ID from network
//
// Flit layout (MSB first): valid, tail, dest[NODE_W], vc, data[DATA_W].
// NODE_W must match the network's node-ID width and FW its flit width.
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_msg_port #(
    parameter int  NODE_W   = 2,
    parameter int  DATA_W   = 16,
    parameter int  RX_DEPTH = 4,
    localparam int FW       = 3 + NODE_W + DATA_W
) (
    input  logic                clk,
    input  logic                res_n,
    // outbound message interface
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [NODE_W-1:0]   tx_dest,
    input  logic [2*DATA_W-1:0] tx_data,
    // inbound message interface
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic [2*DATA_W-1:0] rx_data,
    // sticky error flags
    output logic [2:0]          err,
    // network port
    output logic [FW-1:0]       put_flit,
    output logic                en_put,
    output logic                en_get_non_full_VCs,
    input  logic [1:0]          get_non_full_VCs,
    output logic                en_get,
    input  logic [FW-1:0]       get_flit,
    output logic [1:0]          put_non_full_VCs,
    output logic                en_put_non_full_VCs,
    input  logic [NODE_W-1:0]   this_id
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_AW        = $clog2(RX_DEPTH);
    localparam int c_CW        = c_AW + 1;
    localparam int c_VALID_BIT = FW - 1;
    localparam int c_TAIL_BIT  = FW - 2;
    localparam int c_DEST_MSB  = FW - 3;
    localparam int c_VC_BIT    = DATA_W;

    localparam logic [1:0] c_TX_IDLE = 2'd0;
    localparam logic [1:0] c_TX_HEAD = 2'd1;
    localparam logic [1:0] c_TX_TAIL = 2'd2;

    localparam logic [1:0] c_RX_WANT_HEAD = 2'd0;
    localparam logic [1:0] c_RX_WANT_TAIL = 2'd1;
    localparam logic [1:0] c_RX_OUT       = 2'd2;

    // ------------------------------------------------------------------------
    // Run flag: low in reset, high from the first edge after release. It
    // drives the constant enables and keeps tx_ready low while in reset.
    // ------------------------------------------------------------------------
    logic r_running;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_running <= 1'b0;
        end else begin
            r_running <= 1'b1;
        end
    end

    assign en_get_non_full_VCs = r_running;
    assign en_get              = r_running;
    assign en_put_non_full_VCs = r_running;

    // VC1 is never used for injection, so its status bit is ignored.
    logic w_unusedVc1;
    assign w_unusedVc1 = get_non_full_VCs[1];

    // ------------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------------
    logic [1:0]          r_txState;
    logic [1:0]          w_txStateNext;
    logic [NODE_W-1:0]   r_txDest;
    logic [2*DATA_W-1:0] r_txData;
    logic                w_txReady;
    logic                w_txAccept;
    logic                w_enPut;
    logic                w_putTail;
    logic                w_vc0Free;
    logic [DATA_W-1:0]   w_putData;

    assign w_vc0Free = get_non_full_VCs[0];

    always_comb begin
        w_txStateNext = r_txState;
        w_txReady     = 1'b0;
        w_enPut       = 1'b0;
        w_putTail     = 1'b0;
        case (r_txState)
            c_TX_IDLE: begin
                w_txReady = r_running;
                if (tx_valid && r_running) begin
                    w_txStateNext = c_TX_HEAD;
                end
            end
            c_TX_HEAD: begin
                if (w_vc0Free) begin
                    w_enPut       = 1'b1;
                    w_txStateNext = c_TX_TAIL;
                end
            end
            c_TX_TAIL: begin
                // The cycle the tail leaves is also the cycle the next
                // message may be taken, giving one message per two cycles.
                if (w_vc0Free) begin
                    w_enPut       = 1'b1;
                    w_putTail     = 1'b1;
                    w_txReady     = 1'b1;
                    w_txStateNext = tx_valid ? c_TX_HEAD : c_TX_IDLE;
                end
            end
            default: begin
                w_txStateNext = c_TX_IDLE;
            end
        endcase
    end

    assign w_txAccept = tx_valid && w_txReady;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_txState <= c_TX_IDLE;
            r_txDest  <= '0;
            r_txData  <= '0;
        end else begin
            r_txState <= w_txStateNext;
            if (w_txAccept) begin
                r_txDest <= tx_dest;
                r_txData <= tx_data;
            end
        end
    end

    assign w_putData = w_putTail ? r_txData[DATA_W-1:0] : r_txData[2*DATA_W-1:DATA_W];
    assign tx_ready  = w_txReady;
    assign en_put    = w_enPut;
    assign put_flit  = w_enPut ? {1'b1, w_putTail, r_txDest, 1'b0, w_putData} : '0;

    // ------------------------------------------------------------------------
    // RX FIFO: stores only {tail, data}; dest and vc are consumed on entry.
    // ------------------------------------------------------------------------
    logic [DATA_W:0]     r_mem [RX_DEPTH];
    logic [c_AW-1:0]     r_wrPtr;
    logic [c_AW-1:0]     r_rdPtr;
    logic [c_CW-1:0]     r_count;
    logic [c_CW-1:0]     w_countNext;
    logic                r_credit;
    logic                w_getValid;
    logic                w_getVc;
    logic [NODE_W-1:0]   w_getDest;
    logic                w_vcErr;
    logic                w_misroute;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_overflow;
    logic [DATA_W:0]     w_popFlit;
    logic                w_popTail;
    logic [DATA_W-1:0]   w_popData;
    logic [1:0]          r_rxState;

    assign w_getValid = r_running && get_flit[c_VALID_BIT];
    assign w_getVc    = get_flit[c_VC_BIT];
    assign w_getDest  = get_flit[c_DEST_MSB -: NODE_W];

    assign w_vcErr    = w_getValid && w_getVc;
    // Misrouted flits are still buffered; the flag is only diagnostic.
    assign w_misroute = w_getValid && !w_getVc && (w_getDest != this_id);

    assign w_full  = (r_count == c_CW'(RX_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = (r_rxState != c_RX_OUT) && !w_empty;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_overflow = w_getValid && !w_getVc && w_full && !w_pop;
    assign w_push     = w_getValid && !w_getVc && !w_overflow;

    always_comb begin
        w_countNext = r_count;
        case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + c_CW'(1);
            2'b01:   w_countNext = r_count - c_CW'(1);
            default: w_countNext = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {get_flit[c_TAIL_BIT], get_flit[DATA_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
            r_credit <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_AW'(1);
            end
            r_count <= w_countNext;
            // Advertise space only while two or more slots are free: one slot
            // is held back for a flit the network may already have in flight.
            r_credit <= (w_countNext <= c_CW'(RX_DEPTH - 2));
        end
    end

    assign put_non_full_VCs = {1'b0, r_credit};

    assign w_popFlit = r_mem[r_rdPtr];
    assign w_popTail = w_popFlit[DATA_W];
    assign w_popData = w_popFlit[DATA_W-1:0];

    // ------------------------------------------------------------------------
    // RX reassembly FSM
    // ------------------------------------------------------------------------
    logic [1:0]        w_rxStateNext;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              w_hiLoad;
    logic              w_loLoad;
    logic              w_protoErr;

    always_comb begin
        w_rxStateNext = r_rxState;
        w_hiLoad      = 1'b0;
        w_loLoad      = 1'b0;
        w_protoErr    = 1'b0;
        case (r_rxState)
            c_RX_WANT_HEAD: begin
                if (w_pop) begin
                    if (!w_popTail) begin
                        w_hiLoad      = 1'b1;
                        w_rxStateNext = c_RX_WANT_TAIL;
                    end else begin
                        w_protoErr = 1'b1;
                    end
                end
            end
            c_RX_WANT_TAIL: begin
                if (w_pop) begin
                    if (w_popTail) begin
                        w_loLoad      = 1'b1;
                        w_rxStateNext = c_RX_OUT;
                    end else begin
                        // A second head restarts the message with new data.
                        w_hiLoad   = 1'b1;
                        w_protoErr = 1'b1;
                    end
                end
            end
            c_RX_OUT: begin
                if (rx_ready) begin
                    w_rxStateNext = c_RX_WANT_HEAD;
                end
            end
            default: begin
                w_rxStateNext = c_RX_WANT_HEAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_rxState <= c_RX_WANT_HEAD;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_rxState <= w_rxStateNext;
            if (w_hiLoad) begin
                r_hi <= w_popData;
            end
            if (w_loLoad) begin
                r_lo <= w_popData;
            end
        end
    end

    assign rx_valid = (r_rxState == c_RX_OUT);
    assign rx_data  = {r_hi, r_lo};

    // ------------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------------
    logic [2:0] r_err;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | {w_misroute, (w_vcErr | w_protoErr), w_overflow};
        end
    end

    assign err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_noc_msg_port.sv
// ============================================================================
// Module      : tb_noc_msg_port
// Description : Self-checking bench for noc_msg_port. Outbound vectors come
//               from a table; expected flits and messages go into queues and
//               are compared by a monitor as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_msg_port;

    localparam int NODE_W   = 2;
    localparam int DATA_W   = 16;
    localparam int RX_DEPTH = 4;
    localparam int FW       = 3 + NODE_W + DATA_W;

    logic                clk = 1'b0;
    logic                res_n = 1'b0;
    logic                tx_valid = 1'b0;
    logic                tx_ready;
    logic [NODE_W-1:0]   tx_dest = '0;
    logic [2*DATA_W-1:0] tx_data = '0;
    logic                rx_valid;
    logic                rx_ready = 1'b0;
    logic [2*DATA_W-1:0] rx_data;
    logic [2:0]          err;
    logic [FW-1:0]       put_flit;
    logic                en_put;
    logic                en_get_non_full_VCs;
    logic [1:0]          get_non_full_VCs = 2'b01;
    logic                en_get;
    logic [FW-1:0]       get_flit = '0;
    logic [1:0]          put_non_full_VCs;
    logic                en_put_non_full_VCs;
    logic [NODE_W-1:0]   this_id = 2'd1;

    noc_msg_port #(
        .NODE_W   (NODE_W),
        .DATA_W   (DATA_W),
        .RX_DEPTH (RX_DEPTH)
    ) dut (
        .clk                 (clk),
        .res_n               (res_n),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .tx_dest             (tx_dest),
        .tx_data             (tx_data),
        .rx_valid            (rx_valid),
        .rx_ready            (rx_ready),
        .rx_data             (rx_data),
        .err                 (err),
        .put_flit            (put_flit),
        .en_put              (en_put),
        .en_get_non_full_VCs (en_get_non_full_VCs),
        .get_non_full_VCs    (get_non_full_VCs),
        .en_get              (en_get),
        .get_flit            (get_flit),
        .put_non_full_VCs    (put_non_full_VCs),
        .en_put_non_full_VCs (en_put_non_full_VCs),
        .this_id             (this_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   data;
        logic [1:0]    dest;
        logic [FW-1:0] expHead;
        logic [FW-1:0] expTail;
    } txVec_t;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
    } rxVec_t;

    txVec_t        txVecs [5];
    rxVec_t        rxVecs [3];
    logic [FW-1:0] txQ[$];
    logic [31:0]   rxQ[$];
    int            putLog[$];
    int            compared   = 0;
    int            mismatched = 0;
    int            cyc        = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (res_n) begin
            if (!en_put) begin
                chk("put_flit_idle_zero", put_flit, '0);
            end else begin
                putLog.push_back(cyc);
                chk("en_put_needs_vc0", get_non_full_VCs[0], 1);
                chk("tx_flit_expected", txQ.size() != 0, 1);
                if (txQ.size() != 0) begin
                    chk("tx_flit", put_flit, txQ.pop_front());
                end
            end
            if (rx_valid && rx_ready) begin
                chk("rx_msg_expected", rxQ.size() != 0, 1);
                if (rxQ.size() != 0) begin
                    chk("rx_msg", rx_data, rxQ.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic sendMsg(input int idx);
        bit ok;
        ok       = 1'b0;
        tx_valid = 1'b1;
        tx_data  = txVecs[idx].data;
        tx_dest  = txVecs[idx].dest;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                txQ.push_back(txVecs[idx].expHead);
                txQ.push_back(txVecs[idx].expTail);
                break;
            end
            @(posedge clk); #1;
        end
        chk("tx_accept_in_time", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic putFlit(input logic tail, input logic [1:0] dest, input logic vc, input logic [15:0] data);
        get_flit = {1'b1, tail, dest, vc, data};
        @(posedge clk); #1;
        get_flit = '0;
    endtask

    task automatic sendPair(input logic [15:0] hi, input logic [15:0] lo);
        rxQ.push_back({hi, lo});
        putFlit(1'b0, this_id, 1'b0, hi);
        putFlit(1'b1, this_id, 1'b0, lo);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        res_n    = 1'b0;
        tx_valid = 1'b0;
        get_flit = '0;
        rx_ready = 1'b0;
        txQ.delete();
        rxQ.delete();
        repeat (2) @(posedge clk);
        #1 res_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((txQ.size() != 0 || rxQ.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, txQ.size() + rxQ.size(), 0);
    endtask

    initial begin
        txVecs[0] = '{32'hDEADBEEF, 2'd2, {1'b1, 1'b0, 2'd2, 1'b0, 16'hDEAD}, {1'b1, 1'b1, 2'd2, 1'b0, 16'hBEEF}};
        txVecs[1] = '{32'h01234567, 2'd0, {1'b1, 1'b0, 2'd0, 1'b0, 16'h0123}, {1'b1, 1'b1, 2'd0, 1'b0, 16'h4567}};
        txVecs[2] = '{32'h89ABCDEF, 2'd3, {1'b1, 1'b0, 2'd3, 1'b0, 16'h89AB}, {1'b1, 1'b1, 2'd3, 1'b0, 16'hCDEF}};
        txVecs[3] = '{32'hFFFF0000, 2'd1, {1'b1, 1'b0, 2'd1, 1'b0, 16'hFFFF}, {1'b1, 1'b1, 2'd1, 1'b0, 16'h0000}};
        txVecs[4] = '{32'hA5A55A5A, 2'd2, {1'b1, 1'b0, 2'd2, 1'b0, 16'hA5A5}, {1'b1, 1'b1, 2'd2, 1'b0, 16'h5A5A}};
        rxVecs[0] = '{16'h1111, 16'h2222};
        rxVecs[1] = '{16'h3333, 16'h4444};
        rxVecs[2] = '{16'h5555, 16'h6666};

        // ---- reset state ----
        tx_valid = 1'b1;
        @(negedge clk);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_en_put", en_put, 0);
        chk("rst_put_flit", put_flit, 0);
        chk("rst_credit", put_non_full_VCs, 0);
        chk("rst_err", err, 0);
        chk("rst_enables", {en_get, en_get_non_full_VCs, en_put_non_full_VCs}, 0);
        tx_valid = 1'b0;
        @(posedge clk); #1 res_n = 1'b1;
        @(negedge clk);
        chk("post_rst_enables_pre_edge", {en_get, en_get_non_full_VCs, en_put_non_full_VCs}, 3'b000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_enables", {en_get, en_get_non_full_VCs, en_put_non_full_VCs}, 3'b111);
        chk("post_rst_credit", put_non_full_VCs, 2'b01);
        @(posedge clk); #1;

        // ---- single message timing ----
        sendMsg(0);
        tx_valid = 1'b0;
        @(negedge clk);
        chk("t1_head_en", en_put, 1);
        chk("t1_head_tailbit", put_flit[FW-2], 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_tail_en", en_put, 1);
        chk("t1_tail_tailbit", put_flit[FW-2], 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_after_en", en_put, 0);
        @(posedge clk); #1;

        // ---- back-to-back messages from the table ----
        putLog.delete();
        for (int i = 1; i <= 3; i++) begin
            sendMsg(i);
        end
        tx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_flits", putLog.size(), 6);
        if (putLog.size() == 6) begin
            chk("b2b_span", putLog[5] - putLog[0], 5);
        end

        // ---- VC0 stall during HEAD ----
        get_non_full_VCs = 2'b00;
        sendMsg(4);
        tx_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_en_put", en_put, 0);
            @(posedge clk); #1;
        end
        get_non_full_VCs = 2'b01;
        @(negedge clk);
        chk("stall_release_head", {en_put, put_flit[FW-2]}, 2'b10);
        @(posedge clk); #1;
        waitDrain("stall_drain");

        // ---- RX basic pair ----
        rx_ready = 1'b0;
        sendPair(16'h1234, 16'h5678);
        @(negedge clk);
        chk("rx_not_yet_valid", rx_valid, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rx_hold_valid", rx_valid, 1);
            chk("rx_hold_data", rx_data, 32'h12345678);
            @(posedge clk); #1;
        end
        chk("rx_err_clean", err, 0);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        waitDrain("rx_basic_drain");

        // ---- RX FIFO fill, credit and overflow ----
        sendPair(rxVecs[0].hi, rxVecs[0].lo);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fill_first_in_out", rx_valid, 1);
        rxQ.push_back({rxVecs[1].hi, rxVecs[1].lo});
        rxQ.push_back({rxVecs[2].hi, rxVecs[2].lo});
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            get_flit = {1'b1, k[0], this_id, 1'b0, (k < 2) ? (k == 0 ? rxVecs[1].hi : rxVecs[1].lo)
                                                           : (k == 2 ? rxVecs[2].hi : rxVecs[2].lo)};
            @(negedge clk);
            if (k == 2) chk("credit_at_count2", put_non_full_VCs, 2'b01);
            if (k == 3) chk("credit_at_count3", put_non_full_VCs, 2'b00);
        end
        @(posedge clk); #1;
        get_flit = {1'b1, 1'b0, this_id, 1'b0, 16'hDEAD};
        @(negedge clk);
        chk("credit_at_full", put_non_full_VCs, 2'b00);
        chk("err_before_overflow", err, 3'b000);
        @(posedge clk); #1;
        get_flit = '0;
        @(negedge clk);
        chk("err_overflow", err, 3'b001);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        waitDrain("fill_drain");
        rx_ready = 1'b0;

        // ---- reset aborts a pending TX message ----
        get_non_full_VCs = 2'b00;
        sendMsg(1);
        tx_valid = 1'b0;
        doReset();
        get_non_full_VCs = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_flit", en_put, 0);
            @(posedge clk); #1;
        end
        chk("abort_err_cleared", err, 0);

        // ---- RX error cases, then a clean pair ----
        rx_ready = 1'b1;
        putFlit(1'b1, this_id, 1'b0, 16'hAAAA);
        putFlit(1'b0, this_id, 1'b1, 16'hBBBB);
        putFlit(1'b1, 2'd3, 1'b0, 16'hCCCC);
        sendPair(16'hCAFE, 16'hF00D);
        waitDrain("err_seq_drain");
        chk("err_final", err, 3'b110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
